// File: rtl/merge_pkg.sv
// rtl/merge_pkg.sv - shared types and sizing helpers for the round-robin merge
package merge_pkg;

    typedef logic sel_t;

    localparam sel_t SEL_IN0 = 1'b0;
    localparam sel_t SEL_IN1 = 1'b1;

    // Width of a saturating counter that must hold values 0..burst.
    function automatic int run_width(input int burst);
        return (burst < 1) ? 1 : $clog2(burst + 1);
    endfunction

endpackage

// File: rtl/merge_rr_arbiter_if.sv
// rtl/merge_rr_arbiter_if.sv - two input streams, one merged output stream with source tag
interface merge_rr_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             in0_valid;
    logic             in0_ready;
    logic [WIDTH-1:0] in0_data;
    logic             in1_valid;
    logic             in1_ready;
    logic [WIDTH-1:0] in1_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_sel;

    modport slave (
        input  in0_valid,
        input  in0_data,
        output in0_ready,
        input  in1_valid,
        input  in1_data,
        output in1_ready,
        output out_valid,
        output out_data,
        output out_sel,
        input  out_ready
    );

    modport master (
        output in0_valid,
        output in0_data,
        input  in0_ready,
        output in1_valid,
        output in1_data,
        input  in1_ready,
        input  out_valid,
        input  out_data,
        input  out_sel,
        output out_ready
    );

endinterface

// File: rtl/merge_rr_core.sv
// rtl/merge_rr_core.sv - burst-limited round-robin grant with last-winner and run-length state
module merge_rr_core
    import merge_pkg::*;
#(
    parameter int BURST = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic in0_valid,
    input  logic in1_valid,
    input  logic accept,
    output sel_t g,
    output logic any_grant
);

    localparam int             RW      = run_width(BURST);
    localparam logic [RW-1:0]  RUN_MAX = RW'(BURST);
    localparam logic [RW-1:0]  RUN_ONE = RW'(1);

    sel_t          last_q, last_d;
    logic [RW-1:0] run_q,  run_d;

    always_comb begin
        g         = SEL_IN0;
        any_grant = in0_valid | in1_valid;
        if (in0_valid && in1_valid) begin
            // Keep the incumbent until it has used its burst, then hand over.
            g = (run_q >= RUN_MAX) ? ~last_q : last_q;
        end else if (in1_valid) begin
            g = SEL_IN1;
        end
    end

    always_comb begin
        last_d = last_q;
        run_d  = run_q;
        if (accept) begin
            last_d = g;
            if (g == last_q) begin
                run_d = (run_q >= RUN_MAX) ? RUN_MAX : run_q + RUN_ONE;
            end else begin
                run_d = RUN_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= SEL_IN0;
            run_q  <= '0;
        end else begin
            last_q <= last_d;
            run_q  <= run_d;
        end
    end

endmodule

// File: rtl/merge_rr_arbiter.sv
// rtl/merge_rr_arbiter.sv - 2:1 registered stream merge with built-in fair scheduler and source tag
module merge_rr_arbiter
    import merge_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BURST = 1
) (
    input  logic                clk,
    input  logic                rst,
    merge_rr_arbiter_if.slave   bus
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    sel_t             out_sel_q,   out_sel_d;

    logic load_en;
    logic in0_ready;
    logic in1_ready;
    logic accept;
    sel_t g;
    logic any_grant;

    merge_rr_core #(
        .BURST (BURST)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .in0_valid (bus.in0_valid),
        .in1_valid (bus.in1_valid),
        .accept    (accept),
        .g         (g),
        .any_grant (any_grant)
    );

    // Readies see out_ready combinationally so a draining register refills in the same cycle.
    always_comb begin
        load_en   = !out_valid_q || bus.out_ready;
        in0_ready = !rst && load_en && any_grant && bus.in0_valid && (g == SEL_IN0);
        in1_ready = !rst && load_en && any_grant && bus.in1_valid && (g == SEL_IN1);
        accept    = in0_ready || in1_ready;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_sel_d   = g;
            out_data_d  = (g == SEL_IN1) ? bus.in1_data : bus.in0_data;
        end else if (load_en) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= SEL_IN0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign bus.in0_ready = in0_ready;
    assign bus.in1_ready = in1_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;

    a_one_ready: assert property (@(posedge clk) disable iff (rst) !(in0_ready && in1_ready));

endmodule

// File: tb/tb_merge_rr_arbiter.sv
// tb/tb_merge_rr_arbiter.sv - directed vector bench for merge_rr_arbiter at BURST 1, 2 and 3
module tb_merge_rr_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    merge_rr_arbiter_if #(.WIDTH(8)) i1 ();
    merge_rr_arbiter_if #(.WIDTH(8)) i2 ();
    merge_rr_arbiter_if #(.WIDTH(8)) i3 ();

    merge_rr_arbiter #(.WIDTH(8), .BURST(1)) d1 (.clk(clk), .rst(rst), .bus(i1));
    merge_rr_arbiter #(.WIDTH(8), .BURST(2)) d2 (.clk(clk), .rst(rst), .bus(i2));
    merge_rr_arbiter #(.WIDTH(8), .BURST(3)) d3 (.clk(clk), .rst(rst), .bus(i3));

    typedef struct {
        logic       v0;
        logic [7:0] d0;
        logic       v1;
        logic [7:0] d1;
        logic       ordy;
        logic       r0;
        logic       r1;
        logic       ov;
        logic [7:0] od;
        logic       os;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [7:0] a, input logic v1, input logic [7:0] b,
                         input logic ordy);
        i1.in0_valid = v0; i1.in0_data = a; i1.in1_valid = v1; i1.in1_data = b; i1.out_ready = ordy;
        i2.in0_valid = v0; i2.in0_data = a; i2.in1_valid = v1; i2.in1_data = b; i2.out_ready = ordy;
        i3.in0_valid = v0; i3.in0_data = a; i3.in1_valid = v1; i3.in1_data = b; i3.out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic get_r0(input int b);
        case (b)
            1: return i1.in0_ready;
            2: return i2.in0_ready;
            default: return i3.in0_ready;
        endcase
    endfunction

    function automatic logic get_r1(input int b);
        case (b)
            1: return i1.in1_ready;
            2: return i2.in1_ready;
            default: return i3.in1_ready;
        endcase
    endfunction

    function automatic logic get_ov(input int b);
        case (b)
            1: return i1.out_valid;
            2: return i2.out_valid;
            default: return i3.out_valid;
        endcase
    endfunction

    function automatic logic get_os(input int b);
        case (b)
            1: return i1.out_sel;
            2: return i2.out_sel;
            default: return i3.out_sel;
        endcase
    endfunction

    function automatic logic [7:0] get_od(input int b);
        case (b)
            1: return i1.out_data;
            2: return i2.out_data;
            default: return i3.out_data;
        endcase
    endfunction

    // in0 supplies A0,A1,..; in1 supplies B0,B1,.. from cycle v1_from; bit c of exp_sel is the expected source.
    task automatic run_stream(input int b, input int n, input int v1_from, input logic [31:0] exp_sel,
                              input string tag);
        int         c0 = 0;
        int         c1 = 0;
        int         e0 = 0;
        int         e1 = 0;
        logic       r0;
        logic       r1;
        logic [7:0] ed;
        for (int c = 0; c < n; c++) begin
            drive(1'b1, 8'(160 + c0), (c >= v1_from), 8'(176 + c1), 1'b1);
            #1;
            r0 = get_r0(b);
            r1 = get_r1(b);
            chk($sformatf("%s_onehot%0d", tag, c), {31'd0, r0 & r1}, 32'd0);
            tick();
            if (r0) c0++;
            if (r1) c1++;
            ed = exp_sel[c] ? 8'(176 + e1) : 8'(160 + e0);
            if (exp_sel[c]) e1++; else e0++;
            chk($sformatf("%s_valid%0d", tag, c), {31'd0, get_ov(b)}, 32'd1);
            chk($sformatf("%s_sel%0d", tag, c), {31'd0, get_os(b)}, {31'd0, exp_sel[c]});
            chk($sformatf("%s_data%0d", tag, c), {24'd0, get_od(b)}, {24'd0, ed});
        end
    endtask

    initial begin
        tbl[0]  = '{1'b1, 8'h11, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0};
        tbl[1]  = '{1'b1, 8'h22, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h22, 1'b0};
        tbl[2]  = '{1'b1, 8'h33, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h33, 1'b0};
        tbl[3]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h33, 1'b0};
        tbl[4]  = '{1'b1, 8'hA0, 1'b1, 8'hB0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hB0, 1'b1};
        tbl[5]  = '{1'b1, 8'hA0, 1'b1, 8'hB1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA0, 1'b0};
        tbl[6]  = '{1'b1, 8'hA1, 1'b1, 8'hB1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hB1, 1'b1};
        tbl[7]  = '{1'b1, 8'hA1, 1'b1, 8'hB2, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA1, 1'b0};
        tbl[8]  = '{1'b1, 8'hA2, 1'b1, 8'hB2, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b0};
        tbl[9]  = '{1'b1, 8'hA2, 1'b1, 8'hB2, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b0};
        tbl[10] = '{1'b1, 8'hA2, 1'b1, 8'hB2, 1'b1, 1'b0, 1'b1, 1'b1, 8'hB2, 1'b1};
        tbl[11] = '{1'b1, 8'hA2, 1'b0, 8'hB3, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA2, 1'b0};
        tbl[12] = '{1'b0, 8'hA3, 1'b1, 8'hB3, 1'b1, 1'b0, 1'b1, 1'b1, 8'hB3, 1'b1};
        tbl[13] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hB3, 1'b1};
        tbl[14] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'hB3, 1'b1};

        // Reset behaviour and first grant after release.
        drive(1'b1, 8'hA0, 1'b1, 8'hB0, 1'b1);
        #2;
        chk("rst_r0", {31'd0, i1.in0_ready}, 32'd0);
        chk("rst_r1", {31'd0, i1.in1_ready}, 32'd0);
        chk("rst_ov", {31'd0, i1.out_valid}, 32'd0);
        chk("rst_od", {24'd0, i1.out_data}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_r0", {31'd0, i1.in0_ready}, 32'd1);
        chk("rel_r1", {31'd0, i1.in1_ready}, 32'd0);
        tick();
        chk("rel_sel", {31'd0, i1.out_sel}, 32'd0);
        chk("rel_data", {24'd0, i1.out_data}, 32'hA0);
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        tick();
        chk("idle_ov", {31'd0, i1.out_valid}, 32'd0);
        rst = 1'b1;
        #1;
        chk("idle_rst_ov", {31'd0, i1.out_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 8'h00, 1'b1, 8'h5A, 1'b0);
        tick();
        chk("pre_ov", {31'd0, i1.out_valid}, 32'd1);
        chk("pre_od", {24'd0, i1.out_data}, 32'h5A);
        chk("pre_os", {31'd0, i1.out_sel}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_ov", {31'd0, i1.out_valid}, 32'd0);
        chk("async_od", {24'd0, i1.out_data}, 32'd0);
        chk("async_os", {31'd0, i1.out_sel}, 32'd0);
        chk("async_r1", {31'd0, i1.in1_ready}, 32'd0);

        // Table vectors on the BURST=1 instance.
        do_reset();
        for (int k = 0; k < 15; k++) begin
            drive(tbl[k].v0, tbl[k].d0, tbl[k].v1, tbl[k].d1, tbl[k].ordy);
            #1;
            chk($sformatf("tbl%0d_r0", k), {31'd0, i1.in0_ready}, {31'd0, tbl[k].r0});
            chk($sformatf("tbl%0d_r1", k), {31'd0, i1.in1_ready}, {31'd0, tbl[k].r1});
            tick();
            chk($sformatf("tbl%0d_ov", k), {31'd0, i1.out_valid}, {31'd0, tbl[k].ov});
            chk($sformatf("tbl%0d_od", k), {24'd0, i1.out_data}, {24'd0, tbl[k].od});
            chk($sformatf("tbl%0d_os", k), {31'd0, i1.out_sel}, {31'd0, tbl[k].os});
        end

        // Backpressure hold, then drain plus refill in the same cycle.
        do_reset();
        drive(1'b1, 8'h5A, 1'b0, 8'h00, 1'b0);
        tick();
        drive(1'b1, 8'h5B, 1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("stall%0d_r0", k), {31'd0, i1.in0_ready}, 32'd0);
            chk($sformatf("stall%0d_r1", k), {31'd0, i1.in1_ready}, 32'd0);
            tick();
            chk($sformatf("stall%0d_ov", k), {31'd0, i1.out_valid}, 32'd1);
            chk($sformatf("stall%0d_od", k), {24'd0, i1.out_data}, 32'h5A);
            chk($sformatf("stall%0d_os", k), {31'd0, i1.out_sel}, 32'd0);
        end
        drive(1'b1, 8'h5B, 1'b0, 8'h00, 1'b1);
        #1;
        chk("drain_r0", {31'd0, i1.in0_ready}, 32'd1);
        chk("drain_od", {24'd0, i1.out_data}, 32'h5A);
        tick();
        chk("next_od", {24'd0, i1.out_data}, 32'h5B);
        chk("next_ov", {31'd0, i1.out_valid}, 32'd1);
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        tick();
        chk("empty_ov", {31'd0, i1.out_valid}, 32'd0);

        // Continuous contention and late arrival on each BURST setting.
        do_reset();
        run_stream(1, 6, 0, 32'h0000_002A, "b1");
        do_reset();
        run_stream(3, 9, 0, 32'h0000_0038, "b3");
        do_reset();
        run_stream(2, 11, 5, 32'h0000_0660, "b2");

        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
